// File: rtl/bp_be_ptw.sv
// Page-table walker for BE TLB refill: walks a levels_p-deep radix table, ends in a fill or a fault.
// Optional single-entry walk cache for the top level, enabled with BP_BE_PTW_WALK_CACHE_EN.
module bp_be_ptw #(
    parameter int vtag_width_p = 27,
    parameter int ptag_width_p = 28,
    parameter int levels_p     = 3,
    parameter int pte_width_p  = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [ptag_width_p-1:0]   base_ptag_i,
    input  logic                      flush_i,
    input  logic                      miss_v_i,
    input  logic [vtag_width_p-1:0]   miss_vtag_i,
    output logic                      ready_o,
    output logic                      mem_req_v_o,
    output logic [ptag_width_p+11:0]  mem_req_paddr_o,
    input  logic                      mem_req_ready_i,
    input  logic                      mem_resp_v_i,
    input  logic [pte_width_p-1:0]    mem_resp_data_i,
    output logic                      tlb_w_v_o,
    output logic [vtag_width_p-1:0]   tlb_w_vtag_o,
    output logic [ptag_width_p-1:0]   tlb_w_ptag_o,
    output logic                      fault_v_o,
    output logic [vtag_width_p-1:0]   fault_vtag_o
);

    localparam int lvl_width_lp = (levels_p > 1) ? $clog2(levels_p) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_FILL,
        S_FAULT
    } state_e;

    state_e                    state_q, state_d;
    logic [vtag_width_p-1:0]   vtag_q, vtag_d;
    logic [ptag_width_p-1:0]   table_q, table_d;
    logic [lvl_width_lp-1:0]   level_q, level_d;

    logic [levels_p-1:0][8:0]  vpn;
    assign vpn = vtag_q;

    logic                      pte_v, pte_r, pte_w, pte_x;
    logic                      pte_invalid, pte_leaf, pte_pointer, pte_aligned;
    logic [ptag_width_p-1:0]   pte_ppn;
    logic [ptag_width_p-1:0]   lvl_mask;
    logic                      pte_unused;

    assign pte_v       = mem_resp_data_i[0];
    assign pte_r       = mem_resp_data_i[1];
    assign pte_w       = mem_resp_data_i[2];
    assign pte_x       = mem_resp_data_i[3];
    assign pte_ppn     = mem_resp_data_i[10 +: ptag_width_p];
    assign pte_unused  = ^{mem_resp_data_i[pte_width_p-1:10+ptag_width_p], mem_resp_data_i[9:4]};
    assign pte_invalid = ~pte_v | (pte_w & ~pte_r);
    assign pte_leaf    = ~pte_invalid & (pte_r | pte_x);
    assign pte_pointer = ~pte_invalid & ~pte_leaf;

    // Low ptag bits that a leaf at the current level takes from the vtag (superpage offset).
    always_comb begin
        lvl_mask = '0;
        for (int l = 0; l < levels_p; l++) begin
            if (l < int'(level_q)) lvl_mask[9*l +: 9] = '1;
        end
    end

    assign pte_aligned = ((pte_ppn & lvl_mask) == '0);

`ifdef BP_BE_PTW_WALK_CACHE_EN
    logic                    wc_v_q;
    logic [8:0]              wc_vpn_q;
    logic [ptag_width_p-1:0] wc_ptag_q;
    logic                    wc_hit;

    // A flush in the accept cycle already counts as invalidating the entry.
    assign wc_hit = wc_v_q & ~flush_i & (wc_vpn_q == miss_vtag_i[vtag_width_p-1 -: 9]);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wc_v_q    <= 1'b0;
            wc_vpn_q  <= '0;
            wc_ptag_q <= '0;
        end else if (flush_i || state_q == S_FAULT) begin
            wc_v_q <= 1'b0;
        end else if (state_q == S_RESP && mem_resp_v_i && pte_pointer &&
                     level_q == lvl_width_lp'(levels_p-1)) begin
            wc_v_q    <= 1'b1;
            wc_vpn_q  <= vpn[level_q];
            wc_ptag_q <= pte_ppn;
        end
    end
`else
    logic flush_unused;
    assign flush_unused = flush_i;
`endif

    always_comb begin
        // NOTE: every variable gets its default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        vtag_d  = vtag_q;
        table_d = table_q;
        level_d = level_q;
        case (state_q)
            S_IDLE: begin
                if (miss_v_i) begin
                    vtag_d  = miss_vtag_i;
                    table_d = base_ptag_i;
                    level_d = lvl_width_lp'(levels_p-1);
`ifdef BP_BE_PTW_WALK_CACHE_EN
                    if (wc_hit) begin
                        table_d = wc_ptag_q;
                        level_d = lvl_width_lp'(levels_p-2);
                    end
`endif
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) state_d = S_RESP;
            end
            S_RESP: begin
                if (mem_resp_v_i) begin
                    if (pte_invalid) begin
                        state_d = S_FAULT;
                    end else if (pte_leaf) begin
                        // The leaf ppn reuses the table register; level stays for the superpage merge.
                        table_d = pte_ppn;
                        state_d = pte_aligned ? S_FILL : S_FAULT;
                    end else if (level_q == '0) begin
                        state_d = S_FAULT;
                    end else begin
                        table_d = pte_ppn;
                        level_d = level_q - lvl_width_lp'(1);
                        state_d = S_REQ;
                    end
                end
            end
            S_FILL:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            vtag_q  <= '0;
            table_q <= '0;
            level_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            state_q <= state_d;
            vtag_q  <= vtag_d;
            table_q <= table_d;
            level_q <= level_d;
        end
    end

    assign ready_o         = (state_q == S_IDLE);
    assign mem_req_v_o     = (state_q == S_REQ);
    assign mem_req_paddr_o = (state_q == S_REQ) ? {table_q, vpn[level_q], 3'b000} : '0;
    assign tlb_w_v_o       = (state_q == S_FILL);
    assign tlb_w_vtag_o    = (state_q == S_FILL) ? vtag_q : '0;
    assign tlb_w_ptag_o    = (state_q == S_FILL) ?
                             ((table_q & ~lvl_mask) | (ptag_width_p'(vtag_q) & lvl_mask)) : '0;
    assign fault_v_o       = (state_q == S_FAULT);
    assign fault_vtag_o    = (state_q == S_FAULT) ? vtag_q : '0;

endmodule

// File: tb/tb_bp_be_ptw.sv
// Scoreboard bench for bp_be_ptw: directed walks against a queue-driven memory model.
// Walk-cache expectations follow BP_BE_PTW_WALK_CACHE_EN.
module tb_bp_be_ptw;

    localparam int VW = 27;
    localparam int PW = 28;
    localparam int AW = PW + 12;
    localparam int DW = 64;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [PW-1:0] base_ptag_i;
    logic          flush_i;
    logic          miss_v_i;
    logic [VW-1:0] miss_vtag_i;
    logic          ready_o;
    logic          mem_req_v_o;
    logic [AW-1:0] mem_req_paddr_o;
    logic          mem_req_ready_i;
    logic          mem_resp_v_i;
    logic [DW-1:0] mem_resp_data_i;
    logic          tlb_w_v_o;
    logic [VW-1:0] tlb_w_vtag_o;
    logic [PW-1:0] tlb_w_ptag_o;
    logic          fault_v_o;
    logic [VW-1:0] fault_vtag_o;

    always #5 clk_i = ~clk_i;

    bp_be_ptw dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .base_ptag_i     (base_ptag_i),
        .flush_i         (flush_i),
        .miss_v_i        (miss_v_i),
        .miss_vtag_i     (miss_vtag_i),
        .ready_o         (ready_o),
        .mem_req_v_o     (mem_req_v_o),
        .mem_req_paddr_o (mem_req_paddr_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_resp_v_i    (mem_resp_v_i),
        .mem_resp_data_i (mem_resp_data_i),
        .tlb_w_v_o       (tlb_w_v_o),
        .tlb_w_vtag_o    (tlb_w_vtag_o),
        .tlb_w_ptag_o    (tlb_w_ptag_o),
        .fault_v_o       (fault_v_o),
        .fault_vtag_o    (fault_vtag_o)
    );

    typedef struct {
        bit            fault;
        logic [VW-1:0] vtag;
        logic [PW-1:0] ptag;
        int            lat;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];
    int   tests      = 0;
    int   fails      = 0;
    int   cyc        = 0;
    int   acc_cyc    = 0;
    int   resp_delay = 1;
    int   strobes    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every fill/fault strobe is matched against the next expected walk outcome.
    always @(negedge clk_i) begin
        if (reset_n_i && (tlb_w_v_o || fault_v_o)) begin
            strobes++;
            check("fill_fault_exclusive", 64'(tlb_w_v_o & fault_v_o), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("outcome_is_fault", 64'(fault_v_o), 64'(e.fault));
                if (e.fault) begin
                    check("fault_vtag", 64'(fault_vtag_o), 64'(e.vtag));
                end else begin
                    check("fill_vtag", 64'(tlb_w_vtag_o), 64'(e.vtag));
                    check("fill_ptag", 64'(tlb_w_ptag_o), 64'(e.ptag));
                end
                check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
            end
        end
    end

    // Memory model: checks each accepted request address and answers after resp_delay cycles.
    initial begin
        mem_resp_v_i    = 1'b0;
        mem_resp_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (mem_req_v_o && mem_req_ready_i) begin
                logic [DW-1:0] d;
                d = '0;
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_req", 64'(mem_req_paddr_o), 64'd0 - 64'd1);
                end else begin
                    mem_t m;
                    m = mem_q.pop_front();
                    check("mem_req_paddr", 64'(mem_req_paddr_o), 64'(m.addr));
                    d = m.data;
                end
                @(posedge clk_i);
                repeat (resp_delay - 1) @(posedge clk_i);
                #1;
                mem_resp_v_i    = 1'b1;
                mem_resp_data_i = d;
                @(posedge clk_i);
                #1;
                mem_resp_v_i    = 1'b0;
                mem_resp_data_i = '0;
            end
        end
    end

    task automatic mem_push(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        mem_t m;
        m.addr = addr;
        m.data = data;
        mem_q.push_back(m);
    endtask

    task automatic expect_out(input bit fault, input logic [VW-1:0] vtag,
                              input logic [PW-1:0] ptag, input int lat);
        exp_t e;
        e.fault = fault;
        e.vtag  = vtag;
        e.ptag  = ptag;
        e.lat   = lat;
        exp_q.push_back(e);
    endtask

    task automatic issue_miss(input logic [VW-1:0] vtag);
        int n;
        n = 0;
        @(posedge clk_i);
        #1;
        miss_v_i    = 1'b1;
        miss_vtag_i = vtag;
        do begin
            @(negedge clk_i);
            n++;
        end while (!ready_o && n < 100);
        check("miss_accepted", 64'(ready_o), 64'd1);
        acc_cyc = cyc;
        @(posedge clk_i);
        #1;
        miss_v_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check(name, 64'(exp_q.size() + mem_q.size()), 64'd0);
        exp_q.delete();
        mem_q.delete();
        repeat (2) @(negedge clk_i);
    endtask

    task automatic pulse_flush();
        @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
    endtask

    task automatic full_walk_vtag1(input int lat);
        mem_push(40'h100000, 64'h80001);
        mem_push(40'h200000, 64'hC0001);
        mem_push(40'h300008, 64'h11580F);
        expect_out(1'b0, 27'h1, 28'h456, lat);
        issue_miss(27'h1);
    endtask

    initial begin
        reset_n_i       = 1'b0;
        base_ptag_i     = 28'h100;
        flush_i         = 1'b0;
        miss_v_i        = 1'b0;
        miss_vtag_i     = '0;
        mem_req_ready_i = 1'b1;

        repeat (3) @(negedge clk_i);
        check("reset_ready", 64'(ready_o), 64'd1);
        check("reset_req_v", 64'(mem_req_v_o), 64'd0);
        check("reset_paddr", 64'(mem_req_paddr_o), 64'd0);
        check("reset_strobes", 64'({tlb_w_v_o, fault_v_o}), 64'd0);
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Three-level walk with a level-0 leaf.
        full_walk_vtag1(7);
        wait_done("walk3_done");

        // Same top vpn: the cache (when built) skips the top-level access.
`ifdef BP_BE_PTW_WALK_CACHE_EN
        mem_push(40'h200000, 64'hC0001);
        mem_push(40'h300010, 64'h115C0F);
        expect_out(1'b0, 27'h2, 28'h457, 5);
`else
        mem_push(40'h100000, 64'h80001);
        mem_push(40'h200000, 64'hC0001);
        mem_push(40'h300010, 64'h115C0F);
        expect_out(1'b0, 27'h2, 28'h457, 7);
`endif
        issue_miss(27'h2);
        wait_done("walk_cache_hit_done");

        pulse_flush();
        mem_push(40'h100000, 64'h80001);
        mem_push(40'h200000, 64'hC0001);
        mem_push(40'h300010, 64'h115C0F);
        expect_out(1'b0, 27'h2, 28'h457, 7);
        issue_miss(27'h2);
        wait_done("after_flush_done");

        // Level-1 superpage: aligned fills, misaligned faults.
        pulse_flush();
        mem_push(40'h100000, 64'h80001);
        mem_push(40'h200000, 64'h10000F);
        expect_out(1'b0, 27'h5, 28'h405, 5);
        issue_miss(27'h5);
        wait_done("superpage_done");

        pulse_flush();
        mem_push(40'h100000, 64'h80001);
        mem_push(40'h200000, 64'h10040F);
        expect_out(1'b1, 27'h5, 28'h0, 5);
        issue_miss(27'h5);
        wait_done("superpage_misaligned_done");

        // Invalid PTEs at the top level; the preceding fault left no cached pointer.
        mem_push(40'h100000, 64'h0);
        expect_out(1'b1, 27'h7, 28'h0, 3);
        issue_miss(27'h7);
        wait_done("invalid_v0_done");

        mem_push(40'h100000, 64'h5);
        expect_out(1'b1, 27'h9, 28'h0, 3);
        issue_miss(27'h9);
        wait_done("invalid_w_no_r_done");

        // Pointer PTE at level 0 faults.
        mem_push(40'h100000, 64'h80001);
        mem_push(40'h200000, 64'hC0001);
        mem_push(40'h300008, 64'h1);
        expect_out(1'b1, 27'h1, 28'h0, 7);
        issue_miss(27'h1);
        wait_done("pointer_at_l0_done");

        // Top-level leaves: misaligned faults, aligned gigapage merges 18 vtag bits.
        mem_push(40'h100000, 64'h403);
        expect_out(1'b1, 27'h1, 28'h0, 3);
        issue_miss(27'h1);
        wait_done("giga_misaligned_done");

        mem_push(40'h100150, 64'h10000003);
        expect_out(1'b0, 27'hABCDEF, 28'h7CDEF, 3);
        issue_miss(27'hABCDEF);
        wait_done("gigapage_done");

        // Backpressure: request held stable, a second miss is ignored.
        mem_req_ready_i = 1'b0;
        full_walk_vtag1(10);
        miss_v_i    = 1'b1;
        miss_vtag_i = 27'h3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("bp_req_v", 64'(mem_req_v_o), 64'd1);
            check("bp_paddr", 64'(mem_req_paddr_o), 64'h100000);
            check("bp_ready", 64'(ready_o), 64'd0);
        end
        @(posedge clk_i);
        #1;
        mem_req_ready_i = 1'b1;
        miss_v_i        = 1'b0;
        wait_done("backpressure_done");

        // Reset in RESP abandons the walk; the late response is ignored.
        resp_delay = 4;
        mem_push(40'h100008, 64'h80001);
        issue_miss(27'h40000);
        @(posedge clk_i);
        #2 reset_n_i = 1'b0;
        #1;
        check("midreset_ready", 64'(ready_o), 64'd1);
        check("midreset_req_v", 64'(mem_req_v_o), 64'd0);
        check("midreset_strobes", 64'({tlb_w_v_o, fault_v_o}), 64'd0);
        begin
            int s0;
            s0 = strobes;
            @(negedge clk_i);
            reset_n_i = 1'b1;
            repeat (10) @(negedge clk_i);
            check("stale_resp_no_strobe", 64'(strobes), 64'(s0));
        end
        check("midreset_mem_consumed", 64'(mem_q.size()), 64'd0);
        resp_delay = 1;

        // Reset also empties the walk cache: the walk starts at the root again.
        full_walk_vtag1(7);
        wait_done("post_reset_walk_done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bp_be_ptw.md
Name: bp_be_ptw

Overview:
Hardware page-table walker on the refill side of the BE TLB. It accepts one TLB miss (virtual tag) at a time and walks a multi-level radix page table in memory through a valid/ready request channel and a valid-only response channel. It ends every walk in exactly one of two ways:
- a single-cycle TLB fill write (vtag and ptag) on success, or
- a single-cycle fault indication.

Parameters:
vtag_width_p, 27, virtual tag width; must equal levels_p*9
ptag_width_p, 28, physical tag width; physical address width is ptag_width_p+12
levels_p, 3, page-table levels
pte_width_p, 64, PTE width (8-byte PTEs)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
base_ptag_i  in  ptag_width_p  root table ptag; held stable while ready_o=0
flush_i  in  1  walk-cache invalidate (honoured only with the optional feature)
miss_v_i  in  1  miss request valid
miss_vtag_i  in  vtag_width_p  missing virtual tag
ready_o  out  1  walker idle; a miss is accepted when miss_v_i & ready_o
mem_req_v_o  out  1  PTE read request valid
mem_req_paddr_o  out  ptag_width_p+12  PTE byte address
mem_req_ready_i  in  1  memory accepts request
mem_resp_v_i  in  1  PTE data valid
mem_resp_data_i  in  pte_width_p  PTE data
tlb_w_v_o  out  1  fill strobe
tlb_w_vtag_o  out  vtag_width_p  fill virtual tag
tlb_w_ptag_o  out  ptag_width_p  fill physical tag
fault_v_o  out  1  page-fault strobe
fault_vtag_o  out  vtag_width_p  faulting virtual tag

Behaviour:
- Reset: asynchronous, forces IDLE.
  - ready_o=1; all other outputs 0; internal registers cleared.
  - Reset asserted mid-walk abandons the walk; any late mem_resp_v_i after reset is ignored.
- PTE decode:
  - V = bit0; R, W, X = bits 1..3; ppn = bits [10 +: ptag_width_p].
  - Invalid: V=0, or W=1 with R=0.
  - Leaf: R or X set. Pointer: V=1 with R=W=X=0.
- vpn[l] = miss_vtag[9*l +: 9].
- Request address: mem_req_paddr_o = {table_ptag, vpn[level], 3'b000}.
- States and transitions:
  - IDLE: on accept, latch vtag; table_ptag <- base_ptag_i; level <- levels_p-1; go to REQ.
  - REQ: hold mem_req_v_o=1 with a stable address until mem_req_ready_i; then go to RESP.
  - RESP: wait for mem_resp_v_i.
    - Invalid PTE -> FAULT.
    - Leaf PTE -> FILL if aligned, otherwise FAULT. Aligned means ppn[9*level-1:0]==0.
    - Pointer PTE at level 0 -> FAULT.
    - Otherwise: table_ptag <- ppn; level <- level-1; go to REQ.
  - FILL: tlb_w_v_o=1 for exactly one cycle, then IDLE.
    - tlb_w_ptag_o = {ppn[ptag_width_p-1:9*level], vtag[9*level-1:0]}, which handles superpages.
    - tlb_w_vtag_o = latched vtag.
  - FAULT: fault_v_o=1 for exactly one cycle with fault_vtag_o, then IDLE.
- ready_o=1 only in IDLE. miss_v_i is ignored in every other state.
- mem_resp_v_i is ignored outside RESP.
- At most one outstanding memory request.
- Latency, 1-cycle memory with a level-2 leaf: accept in cycle 0, request in cycle 1, response in cycle 2, fill in cycle 3. Each extra level adds 2 cycles.
- tlb_w_v_o and fault_v_o are never high in the same cycle.

Optional Feature:
BP_BE_PTW_WALK_CACHE_EN
- Enabled:
  - A single-entry walk cache holds {valid, vpn[levels_p-1], next table_ptag}, written whenever a top-level pointer PTE returns.
  - On accept, a hit (valid and matching top vpn) starts the walk at level levels_p-2 using the cached table_ptag, skipping one access.
  - The entry is cleared by reset, by flush_i (any state; it takes effect for the next accept), and by any fault.
- Disabled: no cache storage; every walk starts at the top level; flush_i has no effect.

Test Plan:
- 3-level walk: base_ptag=0x100, miss vtag=0x0000001, zero-wait memory.
  - Requests in order: 0x100000 -> resp 0x80001; 0x200000 -> resp 0xC0001; 0x300008 -> resp 0x11580F.
  - Expect tlb_w_v_o in cycle 7 with vtag=0x1 and ptag=0x456.
- Superpage: level-1 response 0x10000F (ppn 0x400) for vtag=0x5 -> fill ptag=0x405.
  - Repeat with ppn 0x401 -> fault_v_o with vtag 0x5 and no fill.
- Invalid PTE: first response 0x0 -> fault_v_o one cycle later; exactly one memory request issued.
- Backpressure: mem_req_ready_i low for 3 cycles -> mem_req_v_o held with a stable address, no state advance; a second miss_v_i during the walk is ignored (ready_o=0).
- Reset mid-walk: assert reset_n_i=0 in RESP -> immediately ready_o=1 and all strobes 0.
  - A stale mem_resp_v_i after release produces no fill.
- Walk cache (macro on):
  - Second miss vtag=0x0000002 -> first request 0x200000; total latency 2 cycles shorter than the first walk.
  - flush_i, then the same miss -> starts at 0x100000.
